// File: rtl/sb_pkg.sv
// Shared opcode, state and width definitions for the simple-bus command engine.
package sb_pkg;

    localparam int SB_CMD_W  = 4;
    localparam int SB_ADDR_W = 16;

    typedef enum logic [SB_CMD_W-1:0] {
        SB_NOP   = 4'd0,
        SB_COPY  = 4'd1,
        SB_SWAP  = 4'd2,
        SB_CLEAR = 4'd3,
        SB_INC   = 4'd4
    } sb_cmd_e;

    typedef enum logic [2:0] {
        SB_IDLE = 3'd0,
        SB_RD_S = 3'd1,
        SB_RD_D = 3'd2,
        SB_WR_D = 3'd3,
        SB_WR_S = 3'd4,
        SB_FIN  = 3'd5
    } sb_state_e;

endpackage

// File: rtl/sb_mem.sv
// Register-array word memory: one write port, two combinational read ports.
module sb_mem #(
    parameter int ADDR_W = 6,
    parameter int DATA_W = 16
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [ADDR_W-1:0] raddr_a,
    output logic [DATA_W-1:0] rdata_a,
    input  logic [ADDR_W-1:0] raddr_b,
    output logic [DATA_W-1:0] rdata_b
);

    localparam int DEPTH = 1 << ADDR_W;

    logic [DATA_W-1:0] mem [DEPTH];

    // Contents are deliberately not reset.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata_a = mem[raddr_a];
    assign rdata_b = mem[raddr_b];

endmodule

// File: rtl/simple_bus_cmd_engine.sv
// Word-move command engine on an internal memory with a backdoor debug port.
// Optional command/drop statistics counters are enabled by SB_ENGINE_STATS_EN.
import sb_pkg::*;

module simple_bus_cmd_engine #(
    parameter int ADDR_W = 6,
    parameter int DATA_W = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 en,
    input  logic [SB_CMD_W-1:0]  cmd,
    input  logic [SB_ADDR_W-1:0] saddr,
    input  logic [SB_ADDR_W-1:0] daddr,
    output logic                 done,
    output logic                 err,
    output logic                 busy,
    input  logic                 dbg_we,
    input  logic [ADDR_W-1:0]    dbg_addr,
    input  logic [DATA_W-1:0]    dbg_wdata,
    output logic [DATA_W-1:0]    dbg_rdata,
    output logic [15:0]          cmd_cnt,
    output logic [15:0]          drop_cnt
);

    localparam logic [2:0] ST_IDLE = SB_IDLE;
    localparam logic [2:0] ST_RD_S = SB_RD_S;
    localparam logic [2:0] ST_RD_D = SB_RD_D;
    localparam logic [2:0] ST_WR_D = SB_WR_D;
    localparam logic [2:0] ST_WR_S = SB_WR_S;
    localparam logic [2:0] ST_FIN  = SB_FIN;

    logic [2:0]          state_reg, state_next;
    logic [SB_CMD_W-1:0] cmd_reg;
    logic [ADDR_W-1:0]   s_reg, d_reg;
    logic [DATA_W-1:0]   tmp_s_reg, tmp_d_reg;
    logic                err_reg;

    logic                accept;
    logic                uses_s, uses_d, s_oor, d_oor, illegal, bad;
    logic                mem_we;
    logic [ADDR_W-1:0]   mem_waddr, eng_raddr;
    logic [DATA_W-1:0]   mem_wdata, eng_rdata;

    assign busy   = (state_reg != ST_IDLE);
    assign done   = (state_reg == ST_FIN);
    assign err    = done & err_reg;
    assign accept = (state_reg == ST_IDLE) & en;

    // Only the operands an opcode actually uses are range-checked.
    assign uses_s  = (cmd == SB_COPY) || (cmd == SB_SWAP) || (cmd == SB_INC);
    assign uses_d  = uses_s || (cmd == SB_CLEAR);
    assign s_oor   = |saddr[SB_ADDR_W-1:ADDR_W];
    assign d_oor   = |daddr[SB_ADDR_W-1:ADDR_W];
    assign illegal = (cmd > SB_INC);
    assign bad     = illegal | (uses_s & s_oor) | (uses_d & d_oor);

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE: begin
                if (en) begin
                    if (bad || cmd == SB_NOP) state_next = ST_FIN;
                    else if (cmd == SB_CLEAR) state_next = ST_WR_D;
                    else                      state_next = ST_RD_S;
                end
            end
            ST_RD_S: state_next = (cmd_reg == SB_SWAP) ? ST_RD_D : ST_WR_D;
            ST_RD_D: state_next = ST_WR_D;
            ST_WR_D: state_next = (cmd_reg == SB_SWAP) ? ST_WR_S : ST_FIN;
            ST_WR_S: state_next = ST_FIN;
            ST_FIN:  state_next = ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= ST_IDLE;
            err_reg   <= 1'b0;
        end else begin
            state_reg <= state_next;
            if (accept) begin
                cmd_reg <= cmd;
                s_reg   <= saddr[ADDR_W-1:0];
                d_reg   <= daddr[ADDR_W-1:0];
                err_reg <= bad;
            end
            if (state_reg == ST_RD_S) tmp_s_reg <= eng_rdata;
            if (state_reg == ST_RD_D) tmp_d_reg <= eng_rdata;
        end
    end

    assign eng_raddr = (state_reg == ST_RD_D) ? d_reg : s_reg;

    // Debug owns the write port in IDLE; engine writes are dropped under reset.
    always_comb begin
        mem_we    = 1'b0;
        mem_waddr = d_reg;
        mem_wdata = tmp_s_reg;
        case (state_reg)
            ST_IDLE: begin
                mem_we    = dbg_we;
                mem_waddr = dbg_addr;
                mem_wdata = dbg_wdata;
            end
            ST_WR_D: begin
                mem_we    = ~rst;
                mem_waddr = d_reg;
                if (cmd_reg == SB_CLEAR)    mem_wdata = '0;
                else if (cmd_reg == SB_INC) mem_wdata = tmp_s_reg + DATA_W'(1);
                else                        mem_wdata = tmp_s_reg;
            end
            ST_WR_S: begin
                mem_we    = ~rst;
                mem_waddr = s_reg;
                mem_wdata = tmp_d_reg;
            end
            default: ;
        endcase
    end

    sb_mem #(
        .ADDR_W(ADDR_W),
        .DATA_W(DATA_W)
    ) u_mem (
        .clk    (clk),
        .we     (mem_we),
        .waddr  (mem_waddr),
        .wdata  (mem_wdata),
        .raddr_a(eng_raddr),
        .rdata_a(eng_rdata),
        .raddr_b(dbg_addr),
        .rdata_b(dbg_rdata)
    );

`ifdef SB_ENGINE_STATS_EN
    logic [15:0] cmd_cnt_reg, drop_cnt_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            cmd_cnt_reg  <= 16'd0;
            drop_cnt_reg <= 16'd0;
        end else begin
            if (accept && cmd_cnt_reg != 16'hFFFF)
                cmd_cnt_reg <= cmd_cnt_reg + 16'd1;
            if (en && busy && drop_cnt_reg != 16'hFFFF)
                drop_cnt_reg <= drop_cnt_reg + 16'd1;
        end
    end

    assign cmd_cnt  = cmd_cnt_reg;
    assign drop_cnt = drop_cnt_reg;
`else
    assign cmd_cnt  = 16'd0;
    assign drop_cnt = 16'd0;
`endif

endmodule

// File: tb/tb_simple_bus_cmd_engine.sv
// Self-checking bench for simple_bus_cmd_engine against a word-level memory model.
module tb_simple_bus_cmd_engine;

    localparam int AW    = 6;
    localparam int DW    = 16;
    localparam int DEPTH = 64;

    logic          clk = 1'b0;
    logic          rst;
    logic          en;
    logic [3:0]    cmd;
    logic [15:0]   saddr, daddr;
    logic          done, err, busy;
    logic          dbg_we;
    logic [AW-1:0] dbg_addr;
    logic [DW-1:0] dbg_wdata, dbg_rdata;
    logic [15:0]   cmd_cnt, drop_cnt;

    logic [DW-1:0] ref_mem [DEPTH];
    int tests_run    = 0;
    int tests_failed = 0;
    int exp_cmd      = 0;
    int exp_drop     = 0;

    always #5 clk = ~clk;

    simple_bus_cmd_engine #(.ADDR_W(AW), .DATA_W(DW)) dut (
        .clk      (clk),
        .rst      (rst),
        .en       (en),
        .cmd      (cmd),
        .saddr    (saddr),
        .daddr    (daddr),
        .done     (done),
        .err      (err),
        .busy     (busy),
        .dbg_we   (dbg_we),
        .dbg_addr (dbg_addr),
        .dbg_wdata(dbg_wdata),
        .dbg_rdata(dbg_rdata),
        .cmd_cnt  (cmd_cnt),
        .drop_cnt (drop_cnt)
    );

    // Reference: apply a command to ref_mem; return latency and error flag.
    task automatic model(input logic [3:0] c, input logic [15:0] s, input logic [15:0] d,
                         output int lat, output bit e);
        bit s_bad = (s >= 16'(DEPTH));
        bit d_bad = (d >= 16'(DEPTH));
        int si = int'(s) % DEPTH;
        int di = int'(d) % DEPTH;
        logic [DW-1:0] a, b;
        e = 0;
        case (c)
            4'd0: lat = 1;
            4'd1: if (s_bad || d_bad) begin lat = 1; e = 1; end
                  else begin ref_mem[di] = ref_mem[si]; lat = 3; end
            4'd2: if (s_bad || d_bad) begin lat = 1; e = 1; end
                  else begin
                      a = ref_mem[si]; b = ref_mem[di];
                      ref_mem[di] = a; ref_mem[si] = b; lat = 5;
                  end
            4'd3: if (d_bad) begin lat = 1; e = 1; end
                  else begin ref_mem[di] = '0; lat = 2; end
            4'd4: if (s_bad || d_bad) begin lat = 1; e = 1; end
                  else begin ref_mem[di] = DW'((int'(ref_mem[si]) + 1) % 65536); lat = 3; end
            default: begin lat = 1; e = 1; end
        endcase
    endtask

    task automatic bk_write(input int a, input logic [DW-1:0] v);
        @(negedge clk);
        dbg_we = 1; dbg_addr = AW'(a); dbg_wdata = v;
        @(posedge clk); #1;
        dbg_we = 0;
        ref_mem[a] = v;
    endtask

    task automatic check_mem(input string tag);
        int nbad = 0;
        int first = -1;
        logic [DW-1:0] got_v, exp_v;
        for (int a = 0; a < DEPTH; a++) begin
            dbg_addr = AW'(a); #1;
            if (dbg_rdata !== ref_mem[a]) begin
                if (first < 0) begin first = a; got_v = dbg_rdata; exp_v = ref_mem[a]; end
                nbad++;
            end
        end
        tests_run++;
        if (nbad != 0) begin
            tests_failed++;
            $display("FAIL %s mem: %0d words wrong, mem[%0d] got %h want %h", tag, nbad, first, got_v, exp_v);
        end else
            $display("[TB] %s mem sweep ok", tag);
    endtask

    // Issue one command (optionally with a same-cycle debug write) and check its completion.
    task automatic exec_cmd(input logic [3:0] c, input logic [15:0] s, input logic [15:0] d,
                            input bit with_dbg, input int da, input logic [DW-1:0] dv,
                            input string tag);
        int exp_lat, seen;
        bit exp_err, got_err, busy_bad;
        if (with_dbg) ref_mem[da] = dv;
        model(c, s, d, exp_lat, exp_err);
        @(negedge clk);
        en = 1; cmd = c; saddr = s; daddr = d;
        if (with_dbg) begin dbg_we = 1; dbg_addr = AW'(da); dbg_wdata = dv; end
        seen = 0; got_err = 0; busy_bad = 0;
        for (int k = 1; k <= 8; k++) begin
            @(posedge clk); #1;
            if (k == 1) begin en = 0; dbg_we = 0; end
            if (done) begin seen = k; got_err = err; break; end
            if (busy !== 1'b1) busy_bad = 1;
        end
        exp_cmd++;
        tests_run++;
        if (seen != exp_lat) begin
            tests_failed++;
            $display("FAIL %s latency: got %0d want %0d", tag, seen, exp_lat);
        end
        tests_run++;
        if (got_err !== exp_err || busy_bad) begin
            tests_failed++;
            $display("FAIL %s err/busy: err got %0b want %0b, busy dropped %0b", tag, got_err, exp_err, busy_bad);
        end
        @(posedge clk); #1;
        tests_run++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            tests_failed++;
            $display("FAIL %s after-done: done %0b busy %0b want 0 0", tag, done, busy);
        end
        $display("[TB] %s cmd=%0d s=%h d=%h lat=%0d err=%0b", tag, c, s, d, seen, got_err);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1;
        repeat (2) @(posedge clk);
        #1;
        exp_cmd = 0; exp_drop = 0;
        @(negedge clk);
        rst = 0;
    endtask

    task automatic test_reset();
        rst = 1; en = 0; cmd = 0; saddr = 0; daddr = 0;
        dbg_we = 0; dbg_addr = 0; dbg_wdata = 0;
        repeat (3) @(posedge clk);
        #1;
        tests_run++;
        if (done !== 1'b0 || err !== 1'b0 || busy !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset outputs: done %0b err %0b busy %0b want 0 0 0", done, err, busy);
        end
        tests_run++;
        if (cmd_cnt !== 16'd0 || drop_cnt !== 16'd0) begin
            tests_failed++;
            $display("FAIL reset counters: cmd_cnt %0d drop_cnt %0d want 0 0", cmd_cnt, drop_cnt);
        end
        @(negedge clk);
        rst = 0;
        for (int a = 0; a < DEPTH; a++) bk_write(a, DW'($urandom));
        check_mem("reset_preload");
    endtask

    task automatic test_copy();
        bk_write(3, 16'h1234);
        exec_cmd(4'd1, 16'd3, 16'd7, 0, 0, 0, "copy");
        exec_cmd(4'd1, 16'd63, 16'd0, 0, 0, 0, "copy_maxaddr");
        check_mem("copy");
    endtask

    task automatic test_swap();
        bk_write(1, 16'hAAAA);
        bk_write(2, 16'h5555);
        exec_cmd(4'd2, 16'd1, 16'd2, 0, 0, 0, "swap");
        exec_cmd(4'd2, 16'd2, 16'd2, 0, 0, 0, "swap_same");
        check_mem("swap");
    endtask

    task automatic test_inc_clear();
        bk_write(4, 16'hFFFF);
        exec_cmd(4'd4, 16'd4, 16'd5, 0, 0, 0, "inc_wrap");
        exec_cmd(4'd3, 16'd0, 16'd4, 0, 0, 0, "clear");
        exec_cmd(4'd4, 16'd6, 16'd6, 0, 0, 0, "inc_inplace");
        exec_cmd(4'd1, 16'd1, 16'd1, 0, 0, 0, "copy_same");
        check_mem("inc_clear");
    endtask

    task automatic test_errors();
        exec_cmd(4'hF, 16'd0, 16'd0, 0, 0, 0, "illegal_f");
        exec_cmd(4'd5, 16'd1, 16'd2, 0, 0, 0, "illegal_5");
        exec_cmd(4'd1, 16'h0040, 16'd3, 0, 0, 0, "copy_src_oor");
        exec_cmd(4'd3, 16'hFFFF, 16'h8000, 0, 0, 0, "clear_dst_oor");
        exec_cmd(4'd3, 16'hFFFF, 16'd9, 0, 0, 0, "clear_src_unused");
        exec_cmd(4'd0, 16'hFFFF, 16'hFFFF, 0, 0, 0, "nop_oor_unused");
        check_mem("errors");
    endtask

    task automatic test_dbg_same_cycle();
        exec_cmd(4'd1, 16'd10, 16'd11, 1, 10, 16'hBEEF, "dbg_and_copy");
        exec_cmd(4'd4, 16'd12, 16'd13, 1, 12, 16'h7FFF, "dbg_and_inc");
        check_mem("dbg_same_cycle");
    endtask

    // SWAP in flight; a COPY en and a debug write arrive while busy and must be ignored.
    task automatic test_busy();
        int exp_lat, seen;
        bit exp_err, busy_bad;
        do_reset();
        model(4'd2, 16'd20, 16'd21, exp_lat, exp_err);
        @(negedge clk);
        en = 1; cmd = 4'd2; saddr = 16'd20; daddr = 16'd21;
        seen = 0; busy_bad = 0;
        for (int k = 1; k <= 8; k++) begin
            @(posedge clk); #1;
            en = 0; dbg_we = 0;
            if (k == 2) begin
                en = 1; cmd = 4'd1; saddr = 16'd22; daddr = 16'd23;
                dbg_we = 1; dbg_addr = AW'(24); dbg_wdata = ~ref_mem[24];
            end
            if (done) begin seen = k; break; end
            if (busy !== 1'b1) busy_bad = 1;
        end
        en = 0; dbg_we = 0;
        exp_cmd = 1; exp_drop = 1;
        tests_run++;
        if (seen != exp_lat || busy_bad) begin
            tests_failed++;
            $display("FAIL busy_swap: latency got %0d want %0d, busy dropped %0b", seen, exp_lat, busy_bad);
        end
        @(posedge clk); #1;
`ifdef SB_ENGINE_STATS_EN
        tests_run++;
        if (cmd_cnt !== 16'(exp_cmd) || drop_cnt !== 16'(exp_drop)) begin
            tests_failed++;
            $display("FAIL busy_counters: cmd_cnt %0d drop_cnt %0d want %0d %0d", cmd_cnt, drop_cnt, exp_cmd, exp_drop);
        end
`endif
        $display("[TB] busy swap done at %0d with ignored copy", seen);
        check_mem("busy");
    endtask

    task automatic test_reset_midop();
        bit saw_done = 0;
        @(negedge clk);
        en = 1; cmd = 4'd2; saddr = 16'd30; daddr = 16'd31;
        @(posedge clk); #1; en = 0;
        @(posedge clk); #1;
        rst = 1;
        @(posedge clk); #1;
        if (done) saw_done = 1;
        tests_run++;
        if (busy !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_midop busy: got %0b want 0", busy);
        end
        rst = 0;
        exp_cmd = 0; exp_drop = 0;
        repeat (6) begin
            @(posedge clk); #1;
            if (done) saw_done = 1;
        end
        tests_run++;
        if (saw_done) begin
            tests_failed++;
            $display("FAIL reset_midop done: got pulse want none");
        end
        $display("[TB] reset during swap RD_D, no done");
        check_mem("reset_midop");
    endtask

    task automatic test_random();
        logic [3:0] c;
        logic [15:0] s, d;
        int r;
        for (int i = 0; i < 60; i++) begin
            if ($urandom_range(0, 4) == 0) bk_write($urandom_range(0, DEPTH - 1), DW'($urandom));
            r = $urandom_range(0, 9);
            if (r <= 4)      c = 4'(r);
            else if (r <= 8) c = 4'($urandom_range(0, 4));
            else             c = 4'($urandom_range(5, 15));
            s = ($urandom_range(0, 9) == 0) ? 16'($urandom_range(64, 65535)) : 16'($urandom_range(0, DEPTH - 1));
            d = ($urandom_range(0, 9) == 0) ? 16'($urandom_range(64, 65535)) : 16'($urandom_range(0, DEPTH - 1));
            exec_cmd(c, s, d, 0, 0, 0, $sformatf("rand%0d", i));
            if (i % 20 == 19) check_mem($sformatf("rand%0d", i));
        end
`ifdef SB_ENGINE_STATS_EN
        tests_run++;
        if (cmd_cnt !== 16'(exp_cmd) || drop_cnt !== 16'(exp_drop)) begin
            tests_failed++;
            $display("FAIL rand_counters: cmd_cnt %0d drop_cnt %0d want %0d %0d", cmd_cnt, drop_cnt, exp_cmd, exp_drop);
        end
`endif
    endtask

    initial begin
        test_reset();
        test_copy();
        test_swap();
        test_inc_clear();
        test_errors();
        test_dbg_same_cycle();
        test_busy();
        test_reset_midop();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
